// File: rtl/rf_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_seq_pkg
//  Description : Shared defaults, op encoding and FSM state encoding for the
//                register-file operation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rf_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : rf_seq_alu
//  Description : Combinational ALU for the sequencer: ADD/SUB modulo
//                2**DATA_W (carry/borrow dropped), bitwise AND/XOR, and a
//                zero flag on the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Operation select; sums and differences wrap at the data width.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/rf_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_op_sequencer
//  Description : Accepts one register-to-register op per valid/ready
//                handshake, reads both operands from the register file,
//                computes the result and writes it back (IDLE->READ->EXEC->
//                WRITE, one op per four cycles).
//                Optional macro RF_SEQ_ZERO_REG_EN: register 0 reads as zero
//                and is never written.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_rs_a,
    input  logic [ADDR_W-1:0] req_rs_b,
    input  logic [ADDR_W-1:0] req_rd,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] d_out_a,
    input  logic [DATA_W-1:0] d_out_b,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] d_in,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    state_e              r_state;
    state_e              w_next_state;
    logic                r_armed;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [DATA_W-1:0]   r_opnd_a;
    logic [DATA_W-1:0]   r_opnd_b;
    logic [DATA_W-1:0]   w_opnd_a;
    logic [DATA_W-1:0]   w_opnd_b;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_zero;
    logic                w_wr_en;
    logic                w_accept;

    assign req_ready = r_armed && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

`ifdef RF_SEQ_ZERO_REG_EN
    // Register 0 is hardwired to zero: mask reads, suppress writes.
    assign w_opnd_a = (rd_addr_a == '0) ? '0 : d_out_a;
    assign w_opnd_b = (rd_addr_b == '0) ? '0 : d_out_b;
    assign w_wr_en  = (r_rd != '0);
`else
    assign w_opnd_a = d_out_a;
    assign w_opnd_b = d_out_b;
    assign w_wr_en  = 1'b1;
`endif

    rf_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (r_op),
        .a      (r_opnd_a),
        .b      (r_opnd_b),
        .result (w_alu_result),
        .zero   (w_alu_zero)
    );

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a fixed four-phase walk once a request is taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = READ;
            READ:    w_next_state = EXEC;
            EXEC:    w_next_state = WRITE;
            WRITE:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath and port registers; write strobe is presented for the whole
    // WRITE cycle and committed by the register file on its closing edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed   <= 1'b0;
            r_op      <= OP_ADD;
            r_rd      <= '0;
            r_opnd_a  <= '0;
            r_opnd_b  <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            wr        <= 1'b0;
            wr_addr   <= '0;
            d_in      <= '0;
            done      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            wr      <= 1'b0;
            done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= op_e'(req_op);
                        r_rd      <= req_rd;
                        rd_addr_a <= req_rs_a;
                        rd_addr_b <= req_rs_b;
                    end
                end
                READ: begin
                    r_opnd_a <= w_opnd_a;
                    r_opnd_b <= w_opnd_b;
                end
                EXEC: begin
                    result  <= w_alu_result;
                    zero    <= w_alu_zero;
                    wr      <= w_wr_en;
                    wr_addr <= r_rd;
                    d_in    <= w_alu_result;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_op_sequencer
//  Description : Self-checking bench for rf_op_sequencer with a behavioural
//                8x16 register file and an arithmetic reference model.
//                Honours RF_SEQ_ZERO_REG_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_op_sequencer;
    import rf_seq_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_rs_a;
    logic [ADDR_W-1:0] req_rs_b;
    logic [ADDR_W-1:0] req_rd;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] d_out_a;
    logic [DATA_W-1:0] d_out_b;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] d_in;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_op_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs_a  (req_rs_a),
        .req_rs_b  (req_rs_b),
        .req_rd    (req_rd),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .done      (done),
        .result    (result),
        .zero      (zero)
    );

    // Behavioural register file: combinational reads, write on rising edge,
    // plus a bench-side preload port used only while the sequencer is idle.
    logic [DATA_W-1:0] rf [8];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    assign d_out_a = rf[rd_addr_a];
    assign d_out_b = rf[rd_addr_b];

    always @(posedge clk) begin
        if (wr) rf[wr_addr] <= d_in;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    // Count any write strobe while a watch window is open.
    logic watch = 1'b0;
    int   wr_seen = 0;
    always @(posedge wr) if (watch) wr_seen++;

    // Reference register contents as the architecture defines them.
    logic [DATA_W-1:0] exp_rf [8];

    function automatic logic [DATA_W-1:0] model(input logic [1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] opval(input logic [ADDR_W-1:0] addr);
`ifdef RF_SEQ_ZERO_REG_EN
        if (addr == '0) return '0;
`endif
        return exp_rf[addr];
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
        exp_rf[addr] = data;
    endtask

    // Issue one op and follow it cycle by cycle; starts and ends on a negedge.
    task automatic do_op(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] rd,
                         input bit noisy);
        logic [DATA_W-1:0] exp;
        logic              exp_wr;
        logic [31:0]       rnd;
        int                n;
        exp    = model(op, opval(a), opval(b));
        exp_wr = 1'b1;
`ifdef RF_SEQ_ZERO_REG_EN
        if (rd == '0) exp_wr = 1'b0;
`endif
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait ready=%b required=1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_rs_a  = a;
        req_rs_b  = b;
        req_rd    = rd;
        @(negedge clk);
        // READ cycle: busy, addresses driven; request lines now ignored.
        if (noisy) begin
            rnd      = $urandom;
            req_op   = rnd[1:0];
            req_rs_a = rnd[4:2];
            req_rs_b = rnd[7:5];
            req_rd   = rnd[10:8];
        end else begin
            req_valid = 1'b0;
        end
        checks++;
        if ({req_ready, wr, done, rd_addr_a, rd_addr_b} !== {3'b000, a, b}) begin
            failures++;
            $display("FAIL read_phase ready/wr/done/ra/rb=%b/%b/%b/%0d/%0d required=0/0/0/%0d/%0d",
                     req_ready, wr, done, rd_addr_a, rd_addr_b, a, b);
        end
        @(negedge clk);
        // EXEC cycle: still busy, nothing written, noise not latched.
        checks++;
        if ({req_ready, wr, done, rd_addr_a, rd_addr_b} !== {3'b000, a, b}) begin
            failures++;
            $display("FAIL exec_phase ready/wr/done/ra/rb=%b/%b/%b/%0d/%0d required=0/0/0/%0d/%0d",
                     req_ready, wr, done, rd_addr_a, rd_addr_b, a, b);
        end
        req_valid = 1'b0;
        @(negedge clk);
        // WRITE cycle.
        checks++;
        if ({wr, done} !== {exp_wr, 1'b1}) begin
            failures++;
            $display("FAIL write_strobe wr/done=%b/%b required=%b/1", wr, done, exp_wr);
        end
        if (exp_wr) begin
            checks++;
            if (wr_addr !== rd || d_in !== exp) begin
                failures++;
                $display("FAIL write_data addr/data=%0d/%h required=%0d/%h", wr_addr, d_in, rd, exp);
            end
        end
        checks++;
        if (result !== exp || zero !== (exp == '0)) begin
            failures++;
            $display("FAIL result result/zero=%h/%b required=%h/%b", result, zero, exp, (exp == '0));
        end
        if (exp_wr) exp_rf[rd] = exp;
        @(negedge clk);
        // Back in IDLE: strobes dropped, ready again, write committed.
        checks++;
        if ({wr, done, req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL post_write wr/done/ready=%b/%b/%b required=0/0/1", wr, done, req_ready);
        end
        checks++;
        if (rf[rd] !== exp_rf[rd]) begin
            failures++;
            $display("FAIL commit r%0d=%h required=%h", rd, rf[rd], exp_rf[rd]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rnd;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_rs_a  = '0;
        req_rs_b  = '0;
        req_rd    = '0;
        watch     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rnd = $urandom;
            preload(ADDR_W'(i), rnd[15:0]);
        end
        checks++;
        if ({req_ready, wr, done, result, zero, rd_addr_a, rd_addr_b, wr_addr, d_in} !== '0) begin
            failures++;
            $display("FAIL reset_state ready/wr/done/result/zero=%b/%b/%b/%h/%b required=0/0/0/0000/0",
                     req_ready, wr, done, result, zero);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_arm ready=%b required=0", req_ready);
        end
        @(negedge clk);
        checks++;
        if ({req_ready, wr, result} !== {2'b10, 16'h0000}) begin
            failures++;
            $display("FAIL ready_after_arm ready/wr/result=%b/%b/%h required=1/0/0000",
                     req_ready, wr, result);
        end
        watch = 1'b0;
        checks++;
        if (wr_seen != 0) begin
            failures++;
            $display("FAIL reset_wr_glitch count=%0d required=0", wr_seen);
        end
    endtask

    task automatic test_directed();
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        do_op(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0);
        checks++;
        if (rf[3] !== 16'h0008) begin
            failures++;
            $display("FAIL add_r3 value=%h required=0008", rf[3]);
        end
        do_op(OP_SUB, 3'd2, 3'd1, 3'd4, 1'b0);
        checks++;
        if (rf[4] !== 16'hFFFE || zero !== 1'b0) begin
            failures++;
            $display("FAIL sub_r4 value/zero=%h/%b required=FFFE/0", rf[4], zero);
        end
        do_op(OP_XOR, 3'd1, 3'd1, 3'd5, 1'b0);
        checks++;
        if (rf[5] !== 16'h0000 || zero !== 1'b1) begin
            failures++;
            $display("FAIL xor_r5 value/zero=%h/%b required=0000/1", rf[5], zero);
        end
    endtask

    task automatic test_back_to_back();
        do_op(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0);
        do_op(OP_ADD, 3'd1, 3'd2, 3'd6, 1'b0);
        checks++;
        if (rf[1] !== 16'h000A || rf[6] !== 16'h000D) begin
            failures++;
            $display("FAIL back_to_back r1/r6=%h/%h required=000A/000D", rf[1], rf[6]);
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        preload(3'd7, 16'h1234);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_rs_a  = 3'd1;
        req_rs_b  = 3'd2;
        req_rd    = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        watch = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({wr, done, req_ready, result} !== '0) begin
            failures++;
            $display("FAIL mid_reset_clear wr/done/ready/result=%b/%b/%b/%h required=0/0/0/0000",
                     wr, done, req_ready, result);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        watch = 1'b0;
        checks++;
        if (wr_seen != 0 || rf[7] !== 16'h1234) begin
            failures++;
            $display("FAIL mid_reset_no_write wr_count/r7=%0d/%h required=0/1234", wr_seen, rf[7]);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_rearm ready=%b required=1", req_ready);
        end
    endtask

`ifdef RF_SEQ_ZERO_REG_EN
    task automatic test_zero_reg();
        preload(3'd0, 16'h00FF);
        preload(3'd2, 16'h0003);
        do_op(OP_ADD, 3'd0, 3'd2, 3'd0, 1'b0);
        checks++;
        if (result !== 16'h0003 || rf[0] !== 16'h00FF) begin
            failures++;
            $display("FAIL zero_reg result/r0=%h/%h required=0003/00FF", result, rf[0]);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] rnd;
        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            if (rnd[31:30] == 2'b00) preload(rnd[29:27], rnd[15:0]);
            rnd = $urandom;
            do_op(rnd[1:0], rnd[4:2], rnd[7:5], rnd[10:8], rnd[11]);
        end
    endtask

    task automatic test_final_contents();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== exp_rf[i]) begin
                failures++;
                $display("FAIL final_r%0d value=%h required=%h", i, rf[i], exp_rf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
`ifdef RF_SEQ_ZERO_REG_EN
        test_zero_reg();
`endif
        test_random();
        test_final_contents();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
